snoopy_horizontal_fsm: RTL and testbench
========================================

SNOOPY_HORIZONTAL_FSM -- requirements
Module: snoopy_horizontal_fsm

Interface
REQ-001 The block SHALL have parameter X_MIN, default 0, leftmost legal snoopy_x.
REQ-002 The block SHALL have parameter X_MAX, default 152, rightmost legal snoopy_x (160-px field minus 8-px sprite).
REQ-003 The block SHALL have parameter X_START, default 16, snoopy_x after reset.
REQ-004 The block SHALL have parameter MAX_SPEED, default 3, speed ceiling in px/frame.
REQ-005 The block SHALL have parameter ACCEL, default 1, speed change per frame when accelerating or braking.
REQ-006 The block SHALL have port clock  input  1  system clock, rising edge.
REQ-007 The block SHALL have port reset  input  1  reset, asynchronous, active-low; the design has one clock, and reset is asynchronous and active-low.
REQ-008 The block SHALL have port frame_tick  input  1  one-cycle update strobe, one per frame.
REQ-009 The block SHALL have port input_left  input  1  left key held.
REQ-010 The block SHALL have port input_right  input  1  right key held.
REQ-011 The block SHALL have port snoopy_x  output  8  horizontal position, unsigned.
REQ-012 The block SHALL have port x_speed  output  3  current speed magnitude, unsigned.
REQ-013 The block SHALL have port facing_left  output  1  direction of motion/last motion, 1 = left.
REQ-014 The block SHALL have port at_wall  output  1  high when snoopy_x equals X_MIN or X_MAX (combinational from registers).
REQ-015 The block SHALL have port state  output  2  FSM state: S_IDLE_X=00, S_RUN_LEFT=01, S_RUN_RIGHT=10, S_BRAKE=11.

Function
REQ-016 All registers SHALL update only on rising clock edges with frame_tick=1; with frame_tick=0 they SHALL hold.
REQ-017 Command decode SHALL be: left-only = LEFT, right-only = RIGHT, both or neither = NONE.
REQ-018 On each tick, snoopy_x SHALL move by the pre-tick x_speed in the pre-tick facing_left direction; speed/state then update (one-frame latency from key to motion).
REQ-019 Position arithmetic SHALL use 9-bit intermediates; no 8-bit wrap-around is permitted.
REQ-020 Moving right with x+speed > X_MAX: snoopy_x SHALL become X_MAX, x_speed 0, state S_IDLE_X; left mirror with X_MIN, compared as x < X_MIN+speed.
REQ-021 In S_IDLE_X, x_speed SHALL be 0; LEFT -> S_RUN_LEFT, facing_left=1, x_speed=ACCEL; RIGHT -> S_RUN_RIGHT, facing_left=0, x_speed=ACCEL; NONE -> stay.
REQ-022 In S_IDLE_X, a command toward a wall already reached (LEFT at X_MIN, RIGHT at X_MAX) SHALL be ignored (stay idle, speed 0).
REQ-023 In S_RUN_x with the same-direction command, x_speed SHALL become min(x_speed+ACCEL, MAX_SPEED).
REQ-024 In S_RUN_x with NONE or the opposite command -> S_BRAKE; x_speed reduced by ACCEL on that tick.
REQ-025 In S_BRAKE, a command matching facing_left SHALL return to the matching S_RUN_x with x_speed+ACCEL (saturated); otherwise x_speed = x_speed-ACCEL saturating at 0.
REQ-026 Any tick leaving x_speed = 0 after a brake decrement SHALL move state to S_IDLE_X on that tick; direction reversal therefore always passes through S_IDLE_X.
REQ-027 facing_left SHALL change only on S_IDLE_X -> S_RUN_x transitions.
REQ-028 A wall clamp (REQ-020) SHALL override any speed/state update on the same tick.
REQ-029 Legal parameters: X_MIN <= X_START <= X_MAX <= 255, 1 <= ACCEL <= MAX_SPEED <= 7; others are unsupported.

Reset
REQ-030 While reset=0, asynchronously: snoopy_x=X_START, x_speed=0, facing_left=0, state=S_IDLE_X, regardless of clock or frame_tick.
REQ-031 Assertion mid-motion SHALL abort immediately; first update after release is the first frame_tick edge with reset=1.

Verification
REQ-032 Reset pulse -> snoopy_x=16, x_speed=0, state=00, at_wall=0, before any clock edge.
REQ-033 Hold right for 6 ticks from reset -> x_speed after each tick 1,2,3,3,3,3; snoopy_x 16,17,19,22,25,28; state 10.
REQ-034 Release after REQ-033 -> ticks give (x,speed,state) (31,2,11),(33,1,11),(34,0,00); press left afterwards -> next tick state 01, facing_left=1, x=34.
REQ-035 Hold right from x=150 at speed 3 -> snoopy_x=152, x_speed=0, at_wall=1; further right presses keep x=152, state 00.
REQ-036 Both keys held, or keys held with frame_tick=0, from idle -> no change in any output over 10 cycles.
REQ-037 reset driven low between clock edges at speed 3 -> outputs return to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/snoopy_horizontal_fsm.sv
// -----------------------------------------------------------------------------
// snoopy_horizontal_fsm
//
// Horizontal motion controller for the Snoopy sprite. Once per frame
// (frame_tick), the sprite first moves by the speed and direction it held
// before the tick. Speed and state then update from the left/right keys. The
// result is one frame of latency between a key press and visible motion.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   frame_tick   in   one-cycle update strobe, one per frame
//   input_left   in   left key held
//   input_right  in   right key held
//   snoopy_x     out  [7:0] horizontal position
//   x_speed      out  [2:0] current speed magnitude
//   facing_left  out  direction of (last) motion, 1 = left
//   at_wall      out  snoopy_x is at X_MIN or X_MAX
//   state        out  [1:0] IDLE=00, RUN_LEFT=01, RUN_RIGHT=10, BRAKE=11
// -----------------------------------------------------------------------------
module snoopy_horizontal_fsm #(
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 152,
    parameter int X_START   = 16,
    parameter int MAX_SPEED = 3,
    parameter int ACCEL     = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       input_left,
    input  logic       input_right,
    output logic [7:0] snoopy_x,
    output logic [2:0] x_speed,
    output logic       facing_left,
    output logic       at_wall,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE_X    = 2'b00,
        S_RUN_LEFT  = 2'b01,
        S_RUN_RIGHT = 2'b10,
        S_BRAKE     = 2'b11
    } state_t;

    localparam logic [8:0] X_MIN_9  = 9'(X_MIN);
    localparam logic [8:0] X_MAX_9  = 9'(X_MAX);
    localparam logic [7:0] X_MIN_8  = 8'(X_MIN);
    localparam logic [7:0] X_MAX_8  = 8'(X_MAX);
    localparam logic [7:0] X_START_8 = 8'(X_START);
    localparam logic [2:0] ACCEL_3  = 3'(ACCEL);
    localparam logic [3:0] ACCEL_4  = 4'(ACCEL);
    localparam logic [2:0] MAX_3    = 3'(MAX_SPEED);
    localparam logic [3:0] MAX_4    = 4'(MAX_SPEED);

    logic [7:0] x_q, x_d;
    logic [2:0] speed_q, speed_d;
    logic       facing_q, facing_d;
    state_t     state_q, state_d;

    // Command decode: exactly one key pressed gives a direction.
    logic cmd_left, cmd_right;
    assign cmd_left  = input_left & ~input_right;
    assign cmd_right = input_right & ~input_left;

    // Saturating speed arithmetic. The increment uses one spare bit so the
    // sum cannot wrap before it is compared with the ceiling.
    logic [3:0] inc_sum;
    logic [2:0] speed_inc, speed_dec;
    assign inc_sum   = {1'b0, speed_q} + ACCEL_4;
    assign speed_inc = (inc_sum > MAX_4) ? MAX_3 : inc_sum[2:0];
    assign speed_dec = (speed_q < ACCEL_3) ? 3'd0 : (speed_q - ACCEL_3);

    // Position arithmetic uses 9 bits so that the move cannot wrap below 0
    // or above 255.
    logic [8:0] x_9, spd_9, x_right_9;
    logic       clamp_left, clamp_right;
    assign x_9         = {1'b0, x_q};
    assign spd_9       = {6'b0, speed_q};
    assign x_right_9   = x_9 + spd_9;
    assign clamp_left  = facing_q  & (x_9 < (X_MIN_9 + spd_9));
    assign clamp_right = ~facing_q & (x_right_9 > X_MAX_9);

    always_comb begin
        x_d      = x_q;
        speed_d  = speed_q;
        facing_d = facing_q;
        state_d  = state_q;

        if (clamp_left) begin
            // A wall hit overrides every speed and state update.
            x_d     = X_MIN_8;
            speed_d = 3'd0;
            state_d = S_IDLE_X;
        end else if (clamp_right) begin
            x_d     = X_MAX_8;
            speed_d = 3'd0;
            state_d = S_IDLE_X;
        end else begin
            x_d = facing_q ? 8'(x_9 - spd_9) : 8'(x_right_9);

            unique case (state_q)
                S_IDLE_X: begin
                    speed_d = 3'd0;
                    // Speed is 0 in idle, so x_d equals x_q. A press toward
                    // a wall the sprite already touches is ignored.
                    if (cmd_left && (x_q != X_MIN_8)) begin
                        state_d  = S_RUN_LEFT;
                        facing_d = 1'b1;
                        speed_d  = ACCEL_3;
                    end else if (cmd_right && (x_q != X_MAX_8)) begin
                        state_d  = S_RUN_RIGHT;
                        facing_d = 1'b0;
                        speed_d  = ACCEL_3;
                    end
                end
                S_RUN_LEFT, S_RUN_RIGHT: begin
                    if ((state_q == S_RUN_LEFT) ? cmd_left : cmd_right) begin
                        speed_d = speed_inc;
                    end else begin
                        speed_d = speed_dec;
                        state_d = (speed_dec == 3'd0) ? S_IDLE_X : S_BRAKE;
                    end
                end
                S_BRAKE: begin
                    if (facing_q ? cmd_left : cmd_right) begin
                        speed_d = speed_inc;
                        state_d = facing_q ? S_RUN_LEFT : S_RUN_RIGHT;
                    end else begin
                        speed_d = speed_dec;
                        // The sprite must stop fully before it can reverse.
                        state_d = (speed_dec == 3'd0) ? S_IDLE_X : S_BRAKE;
                    end
                end
                default: state_d = S_IDLE_X;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_q      <= X_START_8;
            speed_q  <= 3'd0;
            facing_q <= 1'b0;
            state_q  <= S_IDLE_X;
        end else if (frame_tick) begin
            x_q      <= x_d;
            speed_q  <= speed_d;
            facing_q <= facing_d;
            state_q  <= state_d;
        end
    end

    assign snoopy_x    = x_q;
    assign x_speed     = speed_q;
    assign facing_left = facing_q;
    assign state       = state_q;
    assign at_wall     = (x_q == X_MIN_8) || (x_q == X_MAX_8);

endmodule

// File: tb/tb_snoopy_horizontal_fsm.sv
// -----------------------------------------------------------------------------
// tb_snoopy_horizontal_fsm
//
// Directed bench for snoopy_horizontal_fsm with default parameters. Every
// expected value is hand-derived from the motion rules. Outputs are sampled
// 1 ns after the rising edge or between edges.
// -----------------------------------------------------------------------------
module tb_snoopy_horizontal_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       input_left = 1'b0;
    logic       input_right = 1'b0;
    logic [7:0] snoopy_x;
    logic [2:0] x_speed;
    logic       facing_left;
    logic       at_wall;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    snoopy_horizontal_fsm dut (
        .clock       (clock),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .input_left  (input_left),
        .input_right (input_right),
        .snoopy_x    (snoopy_x),
        .x_speed     (x_speed),
        .facing_left (facing_left),
        .at_wall     (at_wall),
        .state       (state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Check all five outputs as one transaction.
    task automatic chk_all(input string tag, input int ex, input int es,
                           input int est, input int ef, input int ew);
        chk({tag, ".x"},      int'(snoopy_x),    ex);
        chk({tag, ".speed"},  int'(x_speed),     es);
        chk({tag, ".state"},  int'(state),       est);
        chk({tag, ".facing"}, int'(facing_left), ef);
        chk({tag, ".wall"},   int'(at_wall),     ew);
        $display("%s x=%0d speed=%0d state=%0d facing=%0d wall=%0d",
                 tag, snoopy_x, x_speed, state, facing_left, at_wall);
    endtask

    // Apply one frame_tick on the next rising edge, then sample 1 ns later.
    task automatic tick();
        @(negedge clock);
        frame_tick = 1'b1;
        @(posedge clock);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        #2;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int ex, es;

        // Reset asserted before any clock edge.
        #1 reset = 1'b0;
        #2;
        chk_all("reset0", 16, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;

        // Hold right for 6 ticks from reset.
        input_right = 1'b1;
        tick(); chk_all("right1", 16, 1, 2, 0, 0);
        tick(); chk_all("right2", 17, 2, 2, 0, 0);
        tick(); chk_all("right3", 19, 3, 2, 0, 0);
        tick(); chk_all("right4", 22, 3, 2, 0, 0);
        tick(); chk_all("right5", 25, 3, 2, 0, 0);
        tick(); chk_all("right6", 28, 3, 2, 0, 0);

        // Release: brake down to idle.
        input_right = 1'b0;
        tick(); chk_all("brake1", 31, 2, 3, 0, 0);
        tick(); chk_all("brake2", 33, 1, 3, 0, 0);
        tick(); chk_all("brake3", 34, 0, 0, 0, 0);

        // Press left: turn around from idle, no motion yet.
        input_left = 1'b1;
        tick(); chk_all("left1", 34, 1, 1, 1, 0);
        input_left = 1'b0;
        tick(); chk_all("stopL", 33, 0, 0, 1, 0);

        // Both keys held: idle stays put for 10 ticks.
        input_left  = 1'b1;
        input_right = 1'b1;
        repeat (10) tick();
        chk_all("both10", 33, 0, 0, 1, 0);

        // Key held but frame_tick low: nothing changes.
        input_right = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        chk_all("notick10", 33, 0, 0, 1, 0);
        input_left = 1'b0;

        // Right wall: hold right from reset until clamp.
        do_reset();
        chk_all("reset1", 16, 0, 0, 0, 0);
        input_right = 1'b1;
        for (int n = 1; n <= 47; n++) begin
            tick();
            ex = (n == 1) ? 16 : (n == 2) ? 17 : 19 + 3 * (n - 3);
            es = (n < 3) ? n : 3;
            chk("rwalk.x", int'(snoopy_x), ex);
            chk("rwalk.speed", int'(x_speed), es);
        end
        chk_all("rwalk47", 151, 3, 2, 0, 0);
        tick(); chk_all("rclamp", 152, 0, 0, 0, 1);
        tick(); chk_all("rpush1", 152, 0, 0, 0, 1);
        tick(); chk_all("rpush2", 152, 0, 0, 0, 1);
        input_right = 1'b0;

        // Leave the wall to the left, reach speed 3, then reset between edges.
        input_left = 1'b1;
        tick(); chk_all("rl1", 152, 1, 1, 1, 1);
        tick(); chk_all("rl2", 151, 2, 1, 1, 0);
        tick(); chk_all("rl3", 149, 3, 1, 1, 0);
        #2 reset = 1'b0;
        #1;
        chk_all("midreset", 16, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;

        // Left wall: hold left from reset until clamp.
        tick(); chk_all("lw1", 16, 1, 1, 1, 0);
        tick(); chk_all("lw2", 15, 2, 1, 1, 0);
        tick(); chk_all("lw3", 13, 3, 1, 1, 0);
        tick(); chk_all("lw4", 10, 3, 1, 1, 0);
        tick(); chk_all("lw5", 7, 3, 1, 1, 0);
        tick(); chk_all("lw6", 4, 3, 1, 1, 0);
        tick(); chk_all("lw7", 1, 3, 1, 1, 0);
        tick(); chk_all("lclamp", 0, 0, 0, 1, 1);
        tick(); chk_all("lpush", 0, 0, 0, 1, 1);
        input_left = 1'b0;

        // Brake then resume in the same direction from S_BRAKE.
        input_right = 1'b1;
        tick(); chk_all("rb1", 0, 1, 2, 0, 1);
        tick(); chk_all("rb2", 1, 2, 2, 0, 0);
        input_right = 1'b0;
        tick(); chk_all("rb3", 3, 1, 3, 0, 0);
        input_right = 1'b1;
        tick(); chk_all("rb4", 4, 2, 2, 0, 0);
        input_right = 1'b0;
        input_left  = 1'b1;
        tick(); chk_all("rb5", 6, 1, 3, 0, 0);
        tick(); chk_all("rb6", 7, 0, 0, 0, 0);
        input_left = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
